// File: rtl/bit_serial_pkg.sv
// Shared types and defaults for the bit serializer: FSM encoding, default widths
// and a reference popcount helper.
package bit_serial_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Popcount of a word zero-extended to 16 bits (the widest legal WIDTH).
    function automatic logic [CNT_W_DEF-1:0] ones_of(input logic [15:0] word);
        logic [CNT_W_DEF-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + CNT_W_DEF'(word[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bit_shift_reg.sv
// Loadable right-shift register; zeros enter at the MSB so bit 0 always holds
// the next bit to transmit.
module bit_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter, LSB first, with valid/last framing and a
// registered count of the 1s in the last completed word.
module bit_serializer
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic [CNT_W-1:0] ones_count,
    output logic             done,
    output state_t           dbg_state
);

    // Handshake: a word is taken at a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, so in_valid is ignored while busy.
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   idx_q;
    logic [CNT_W-1:0]   ones_q;
    logic               load;
    logic               shift;
    logic               last_bit;

    assign load      = (state_q == IDLE) && in_valid;
    assign shift     = (state_q == SHIFT);
    assign last_bit  = (idx_q == CNT_W'(WIDTH - 1));
    assign dbg_state = state_q;

    bit_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .d     (in_data),
        .q     (shreg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ones_count is loaded on the final shift edge so it is already valid
    // in the cycle where done pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q      <= '0;
            ones_q     <= '0;
            ones_count <= '0;
        end else if (load) begin
            idx_q  <= '0;
            ones_q <= '0;
        end else if (shift) begin
            idx_q  <= idx_q + 1'b1;
            ones_q <= ones_q + CNT_W'(shreg[0]);
            if (last_bit) begin
                ones_count <= ones_q + CNT_W'(shreg[0]);
            end
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg[0];
                ser_last  = last_bit;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (WIDTH 8, 2, 16) driven one at a time
// and checked cycle by cycle against a bit queue built from the sent word.
module tb_bit_serializer;
    import bit_serial_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tb_data;
    logic        v_a, v_b, v_c;
    int          sel;
    int          n_checks = 0;
    int          n_err = 0;
    logic [0:0]  exp_q[$];

    logic       rdy_a, so_a, sv_a, sl_a, dn_a;
    logic       rdy_b, so_b, sv_b, sl_b, dn_b;
    logic       rdy_c, so_c, sv_c, sl_c, dn_c;
    logic [4:0] oc_a, oc_b, oc_c;
    state_t     st_a, st_b, st_c;

    logic       obs_ready, obs_ser, obs_sv, obs_last, obs_done;
    logic [4:0] obs_ones;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .CNT_W(5)) dut_a (
        .clk(clk), .reset(reset), .in_data(tb_data[7:0]), .in_valid(v_a),
        .in_ready(rdy_a), .ser_out(so_a), .ser_valid(sv_a), .ser_last(sl_a),
        .ones_count(oc_a), .done(dn_a), .dbg_state(st_a)
    );

    bit_serializer #(.WIDTH(2), .CNT_W(5)) dut_b (
        .clk(clk), .reset(reset), .in_data(tb_data[1:0]), .in_valid(v_b),
        .in_ready(rdy_b), .ser_out(so_b), .ser_valid(sv_b), .ser_last(sl_b),
        .ones_count(oc_b), .done(dn_b), .dbg_state(st_b)
    );

    bit_serializer #(.WIDTH(16), .CNT_W(5)) dut_c (
        .clk(clk), .reset(reset), .in_data(tb_data), .in_valid(v_c),
        .in_ready(rdy_c), .ser_out(so_c), .ser_valid(sv_c), .ser_last(sl_c),
        .ones_count(oc_c), .done(dn_c), .dbg_state(st_c)
    );

    always_comb begin
        obs_ready = rdy_a; obs_ser = so_a; obs_sv = sv_a;
        obs_last  = sl_a;  obs_done = dn_a; obs_ones = oc_a;
        case (sel)
            1: begin
                obs_ready = rdy_b; obs_ser = so_b; obs_sv = sv_b;
                obs_last  = sl_b;  obs_done = dn_b; obs_ones = oc_b;
            end
            2: begin
                obs_ready = rdy_c; obs_ser = so_c; obs_sv = sv_c;
                obs_last  = sl_c;  obs_done = dn_c; obs_ones = oc_c;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input int s, input logic val);
        case (s)
            1:       v_b = val;
            2:       v_c = val;
            default: v_a = val;
        endcase
    endtask

    // Send one word on instance s and check every cycle through the IDLE after DONE.
    task automatic run_word(input int s, input logic [15:0] data, input int w,
                            input bit hold, input bit glitch);
        logic [15:0] d;
        logic [4:0]  exp_ones;
        logic [0:0]  b;
        int          guard;
        sel = s;
        guard = 0;
        while (obs_ready !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        check("accept_ready", {31'd0, obs_ready}, 32'd1);
        d = data;
        exp_q.delete();
        for (int i = 0; i < w; i++) exp_q.push_back(d[i]);
        exp_ones = ones_of(d);
        tb_data = data;
        set_valid(s, 1'b1);
        step();
        if (!hold) set_valid(s, 1'b0);
        for (int i = 0; i < w; i++) begin
            b = exp_q.pop_front();
            check("ser_valid", {31'd0, obs_sv}, 32'd1);
            check("ser_out", {31'd0, obs_ser}, {31'd0, b});
            check("ser_last", {31'd0, obs_last}, (i == w - 1) ? 32'd1 : 32'd0);
            check("busy_ready", {31'd0, obs_ready}, 32'd0);
            check("done_early", {31'd0, obs_done}, 32'd0);
            if (glitch && i == 2) begin
                tb_data = ~data;
                set_valid(s, 1'b1);
            end
            if (glitch && i == 3) set_valid(s, 1'b0);
            step();
        end
        check("done_pulse", {31'd0, obs_done}, 32'd1);
        check("done_sv", {31'd0, obs_sv}, 32'd0);
        check("done_ser", {31'd0, obs_ser}, 32'd0);
        check("done_ready", {31'd0, obs_ready}, 32'd0);
        check("ones_count", {27'd0, obs_ones}, {27'd0, exp_ones});
        step();
        check("idle_ready", {31'd0, obs_ready}, 32'd1);
        check("idle_done", {31'd0, obs_done}, 32'd0);
        check("idle_sv", {31'd0, obs_sv}, 32'd0);
        check("ones_hold", {27'd0, obs_ones}, {27'd0, exp_ones});
    endtask

    initial begin
        logic [15:0] rw;
        bit          hold;
        sel = 0;
        v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
        tb_data = '0;
        reset = 1'b0;
        #20;
        reset = 1'b1;
        #1;
        check("rst_ready", {31'd0, rdy_a}, 32'd1);
        check("rst_sv", {31'd0, sv_a}, 32'd0);
        check("rst_ser", {31'd0, so_a}, 32'd0);
        check("rst_ones", {27'd0, oc_a}, 32'd0);
        check("rst_done", {31'd0, dn_a}, 32'd0);
        check("rst_state", {30'd0, st_a}, {30'd0, IDLE});

        run_word(0, 16'h00A5, 8, 1'b0, 1'b0);

        // Back-to-back with in_valid held high across the frame boundary.
        run_word(0, 16'h00FF, 8, 1'b1, 1'b0);
        run_word(0, 16'h0000, 8, 1'b0, 1'b0);

        run_word(0, 16'h005A, 8, 1'b0, 1'b1);

        // Abort 8'h3C after its 3rd bit with an asynchronous reset.
        sel = 0;
        tb_data = 16'h003C;
        v_a = 1'b1;
        step();
        v_a = 1'b0;
        check("abort_b0", {31'd0, so_a}, 32'd0);
        step();
        check("abort_b1", {31'd0, so_a}, 32'd0);
        step();
        check("abort_b2", {31'd0, so_a}, 32'd1);
        step();
        check("abort_busy", {31'd0, sv_a}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_sv", {31'd0, sv_a}, 32'd0);
        check("async_ser", {31'd0, so_a}, 32'd0);
        check("async_last", {31'd0, sl_a}, 32'd0);
        check("async_ready", {31'd0, rdy_a}, 32'd1);
        check("async_ones", {27'd0, oc_a}, 32'd0);
        check("async_done", {31'd0, dn_a}, 32'd0);
        repeat (3) begin
            step();
            check("rst_hold_done", {31'd0, dn_a}, 32'd0);
        end
        #3;
        reset = 1'b1;
        step();
        check("post_rst_done", {31'd0, dn_a}, 32'd0);
        check("post_rst_ones", {27'd0, oc_a}, 32'd0);
        run_word(0, 16'h0081, 8, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            rw = 16'($urandom_range(0, 255));
            hold = (k < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_word(0, rw, 8, hold, 1'b0);
        end

        run_word(2, 16'hFFFF, 16, 1'b0, 1'b0);
        run_word(2, 16'($urandom_range(0, 65535)), 16, 1'b0, 1'b0);
        run_word(1, 16'h0002, 2, 1'b0, 1'b0);
        run_word(1, 16'h0001, 2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
